// File: rtl/issue_queue.sv
// In-order issue buffer between decoder and execute: circular queue of decoded
// instructions whose queued source operands are patched from the execute writeback.
module issue_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  // decoder side
  input  logic                     dec_in_valid,
  output logic                     dec_in_ready,
  input  logic [6:0]               dec_in_op,
  input  logic [2:0]               dec_in_funct3,
  input  logic [XLEN-1:0]          dec_in_imm,
  input  logic [4:0]               dec_in_rd,
  input  logic [4:0]               dec_in_rs1,
  input  logic [4:0]               dec_in_rs2,
  input  logic [XLEN-1:0]          dec_in_rs1_val,
  input  logic [XLEN-1:0]          dec_in_rs2_val,
  // execute side
  output logic                     dec_out_valid,
  input  logic                     dec_out_ready,
  output logic [6:0]               dec_out_op,
  output logic [2:0]               dec_out_funct3,
  output logic [XLEN-1:0]          dec_out_imm,
  output logic [4:0]               dec_out_rd,
  output logic [4:0]               dec_out_rs1,
  output logic [4:0]               dec_out_rs2,
  output logic [XLEN-1:0]          dec_out_rs1_val,
  output logic [XLEN-1:0]          dec_out_rs2_val,
  // writeback of the instruction issued this cycle
  input  logic [4:0]               wb_rd_idx,
  input  logic [XLEN-1:0]          wb_rd_val,
  input  logic                     wb_valid,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          in_entry;
  entry_t          in_patched;
  entry_t          head_entry;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   rel [DEPTH];
  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] keep;
  logic            enq;
  logic            deq;
  logic            patch_en;

  assign dec_in_ready  = (count != CW'(DEPTH)) && !flush;
  assign dec_out_valid = (count != '0) && !flush;
  assign enq           = dec_in_valid && dec_in_ready;
  assign deq           = dec_out_valid && dec_out_ready;
  assign patch_en      = wb_valid && (wb_rd_idx != 5'd0);

  assign in_entry = '{op: dec_in_op, funct3: dec_in_funct3, imm: dec_in_imm,
                      rd: dec_in_rd, rs1: dec_in_rs1, rs2: dec_in_rs2,
                      rs1_val: dec_in_rs1_val, rs2_val: dec_in_rs2_val};

  // Head goes straight from storage so the ALU never sees a path back to dec_in.
  assign head_entry      = mem[head];
  assign dec_out_op      = head_entry.op;
  assign dec_out_funct3  = head_entry.funct3;
  assign dec_out_imm     = head_entry.imm;
  assign dec_out_rd      = head_entry.rd;
  assign dec_out_rs1     = head_entry.rs1;
  assign dec_out_rs2     = head_entry.rs2;
  assign dec_out_rs1_val = head_entry.rs1_val;
  assign dec_out_rs2_val = head_entry.rs2_val;

  always_comb begin
    in_patched = in_entry;
    if (patch_en && (in_entry.rs1 == wb_rd_idx)) in_patched.rs1_val = wb_rd_val;
    if (patch_en && (in_entry.rs2 == wb_rd_idx)) in_patched.rs2_val = wb_rd_val;
  end

  // A slot survives this edge if it is occupied and is not the one being issued.
  always_comb begin
    live = '0;
    keep = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel[i]  = PW'(i) - head;
      live[i] = ({1'b0, rel[i]} < count);
      keep[i] = live[i] && !(deq && (PW'(i) == head));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (patch_en && keep[i]) begin
        if (mem[i].rs1 == wb_rd_idx) mem[i].rs1_val <= wb_rd_val;
        if (mem[i].rs2 == wb_rd_idx) mem[i].rs2_val <= wb_rd_val;
      end
    end
    if (enq) mem[tail] <= in_patched;
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (deq) head <= head + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (!rst) count <= CW'(DEPTH));

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: fill/full, wrap-around order, operand patching,
// x0 immunity, flush and mid-stream reset.
module tb_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_in_valid, dec_in_ready;
  logic [6:0]  dec_in_op;
  logic [2:0]  dec_in_funct3;
  logic [31:0] dec_in_imm;
  logic [4:0]  dec_in_rd, dec_in_rs1, dec_in_rs2;
  logic [31:0] dec_in_rs1_val, dec_in_rs2_val;
  logic        dec_out_valid, dec_out_ready;
  logic [6:0]  dec_out_op;
  logic [2:0]  dec_out_funct3;
  logic [31:0] dec_out_imm;
  logic [4:0]  dec_out_rd, dec_out_rs1, dec_out_rs2;
  logic [31:0] dec_out_rs1_val, dec_out_rs2_val;
  logic [4:0]  wb_rd_idx;
  logic [31:0] wb_rd_val;
  logic        wb_valid;
  logic        flush;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;

  issue_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .dec_in_valid(dec_in_valid), .dec_in_ready(dec_in_ready),
    .dec_in_op(dec_in_op), .dec_in_funct3(dec_in_funct3), .dec_in_imm(dec_in_imm),
    .dec_in_rd(dec_in_rd), .dec_in_rs1(dec_in_rs1), .dec_in_rs2(dec_in_rs2),
    .dec_in_rs1_val(dec_in_rs1_val), .dec_in_rs2_val(dec_in_rs2_val),
    .dec_out_valid(dec_out_valid), .dec_out_ready(dec_out_ready),
    .dec_out_op(dec_out_op), .dec_out_funct3(dec_out_funct3), .dec_out_imm(dec_out_imm),
    .dec_out_rd(dec_out_rd), .dec_out_rs1(dec_out_rs1), .dec_out_rs2(dec_out_rs2),
    .dec_out_rs1_val(dec_out_rs1_val), .dec_out_rs2_val(dec_out_rs2_val),
    .wb_rd_idx(wb_rd_idx), .wb_rd_val(wb_rd_val), .wb_valid(wb_valid),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // imm carries a unique id so order and identity can be checked at dec_out
  task automatic applyStimulus(input logic in_valid, input logic [31:0] id,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] rs1v, input logic [31:0] rs2v,
                               input logic out_ready);
    dec_in_valid   = in_valid;
    dec_in_op      = 7'h33;
    dec_in_funct3  = 3'd0;
    dec_in_imm     = id;
    dec_in_rd      = rd;
    dec_in_rs1     = rs1;
    dec_in_rs2     = rs2;
    dec_in_rs1_val = rs1v;
    dec_in_rs2_val = rs2v;
    dec_out_ready  = out_ready;
  endtask

  task automatic setWb(input logic v, input logic [4:0] idx, input logic [31:0] val);
    wb_valid  = v;
    wb_rd_idx = idx;
    wb_rd_val = val;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int q[$];
  int sent, recv, cyc;
  logic m_ready, m_valid;

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
    setWb(1'b0, 0, 0);

    // reset and fill
    step();
    step();
    rst = 1'b1;
    checkOutput("reset_count", count, 0);
    checkOutput("reset_valid", dec_out_valid, 0);
    checkOutput("reset_ready", dec_in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 100 + k, 1, 2, 3, 0, 0, 1'b0);
      step();
      checkOutput("fill_count", count, k + 1);
    end
    checkOutput("full_ready", dec_in_ready, 0);
    applyStimulus(1'b1, 104, 1, 2, 3, 0, 0, 1'b0);
    step();
    checkOutput("full_count_hold", count, 4);
    checkOutput("full_head", dec_out_imm, 100);
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
    #1;
    for (int k = 0; k < 4; k++) begin
      checkOutput("drain_head", dec_out_imm, 100 + k);
      step();
    end
    checkOutput("drain_count", count, 0);
    checkOutput("drain_valid", dec_out_valid, 0);

    // wrap-around with alternating consumer
    sent = 0; recv = 0; cyc = 0;
    while (recv < 10 && cyc < 100) begin
      applyStimulus(sent < 10, 200 + sent, 1, 2, 3, 0, 0, cyc[0]);
      #1;
      m_ready = (q.size() != 4);
      m_valid = (q.size() != 0);
      checkOutput("stream_ready", dec_in_ready, m_ready);
      checkOutput("stream_valid", dec_out_valid, m_valid);
      if (m_valid) checkOutput("stream_order", dec_out_imm, q[0]);
      if (m_valid && dec_out_ready) begin
        void'(q.pop_front());
        recv++;
      end
      if (dec_in_valid && m_ready) begin
        q.push_back(200 + sent);
        sent++;
      end
      step();
      checkOutput("stream_count", count, q.size());
      checkOutput("stream_bound", count > 4, 0);
      cyc++;
    end
    checkOutput("stream_done", recv, 10);

    // forwarding to a queued dependant
    applyStimulus(1'b1, 300, 5, 1, 2, 0, 0, 1'b0);
    step();
    applyStimulus(1'b1, 301, 6, 5, 7, 32'h0, 32'h77, 1'b0);
    step();
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
    setWb(1'b1, 5, 32'h12345678);
    step();
    setWb(1'b0, 0, 0);
    checkOutput("fwd_head", dec_out_imm, 301);
    checkOutput("fwd_rs1_val", dec_out_rs1_val, 32'h12345678);
    checkOutput("fwd_rs2_val", dec_out_rs2_val, 32'h77);
    checkOutput("fwd_count", count, 1);
    step();
    checkOutput("fwd_empty", count, 0);

    // same-cycle enqueue patch
    applyStimulus(1'b1, 400, 3, 1, 2, 0, 0, 1'b0);
    step();
    applyStimulus(1'b1, 401, 8, 3, 3, 32'h1111, 32'h2222, 1'b1);
    setWb(1'b1, 3, 32'hDEAD);
    step();
    setWb(1'b0, 0, 0);
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
    checkOutput("same_count", count, 1);
    checkOutput("same_head", dec_out_imm, 401);
    checkOutput("same_rs1_val", dec_out_rs1_val, 32'hDEAD);
    checkOutput("same_rs2_val", dec_out_rs2_val, 32'hDEAD);
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
    step();
    checkOutput("same_empty", count, 0);

    // x0 writeback never patches
    applyStimulus(1'b1, 500, 4, 0, 0, 0, 0, 1'b0);
    step();
    applyStimulus(1'b1, 501, 4, 0, 0, 0, 0, 1'b0);
    setWb(1'b1, 0, 32'hFFFFFFFF);
    step();
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
    step();
    checkOutput("x0_rs1_val", dec_out_rs1_val, 0);
    checkOutput("x0_rs2_val", dec_out_rs2_val, 0);
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
    step();
    checkOutput("x0_head2", dec_out_imm, 501);
    checkOutput("x0_rs1_val2", dec_out_rs1_val, 0);
    setWb(1'b0, 0, 0);
    step();
    checkOutput("x0_empty", count, 0);

    // flush mid-stream
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 600 + k, 1, 2, 3, 0, 0, 1'b0);
      step();
    end
    checkOutput("pre_flush_count", count, 3);
    applyStimulus(1'b1, 699, 1, 2, 3, 0, 0, 1'b1);
    flush = 1'b1;
    #1;
    checkOutput("flush_ready", dec_in_ready, 0);
    checkOutput("flush_valid", dec_out_valid, 0);
    step();
    flush = 1'b0;
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
    #1;
    checkOutput("post_flush_count", count, 0);
    checkOutput("post_flush_valid", dec_out_valid, 0);
    checkOutput("post_flush_ready", dec_in_ready, 1);
    applyStimulus(1'b1, 610, 1, 2, 3, 0, 0, 1'b0);
    step();
    checkOutput("post_flush_head", dec_out_imm, 610);
    checkOutput("post_flush_one", count, 1);

    // reset mid-stream discards entries
    applyStimulus(1'b1, 611, 1, 2, 3, 0, 0, 1'b0);
    step();
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    checkOutput("midreset_count", count, 0);
    checkOutput("midreset_valid", dec_out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
